// File: rtl/gate_vector_sequencer.sv
// Stimulus sequencer for the three-input gate cell.
// Walks {a,b,c} through one of four patterns and hands each vector to the
// downstream capture logic over a valid/ready handshake. A sequence can be
// counted (vec_idx), restarted (start in DONE) or abandoned (abort).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no sequence active, vec_valid low, waiting for start
// RUN   | presenting vectors; busy high; advances on vec_valid & vec_ready
// DONE  | last vector accepted; one cycle only, start here restarts at once
module gate_vector_sequencer #(
    parameter int              N_IN      = 3,
    parameter logic [N_IN-1:0] LFSR_TAPS = 3'b110,
    parameter logic [N_IN-1:0] LFSR_SEED = 3'b111
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      mode,
    input  logic            vec_ready,
    output logic [N_IN-1:0] vec_out,
    output logic            vec_valid,
    output logic [N_IN:0]   vec_idx,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;
    localparam logic [1:0] MODE_LFSR = 2'd3;

    // Index of the final vector for each pattern (sequence length minus one).
    localparam logic [N_IN:0] LAST_FULL = (N_IN+1)'(2**N_IN - 1);
    localparam logic [N_IN:0] LAST_WALK = (N_IN+1)'(N_IN - 1);
    localparam logic [N_IN:0] LAST_LFSR = (N_IN+1)'(2**N_IN - 2);

    localparam logic [N_IN-1:0] ONE_HOT0 = {{(N_IN-1){1'b0}}, 1'b1};

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic [1:0]      mode_q;
    logic [1:0]      mode_n;
    logic [N_IN-1:0] lfsr;
    logic [N_IN-1:0] lfsr_n;
    logic [N_IN-1:0] lfsr_adv;
    logic [N_IN-1:0] vec_out_n;
    logic            vec_valid_n;
    logic [N_IN:0]   vec_idx_n;
    logic [N_IN:0]   idx_inc;
    logic [N_IN:0]   last_idx;
    logic            done_n;
    logic            accept;

    // Pattern generator: vector for index i under mode m. The LFSR pattern
    // does not depend on i; its state is carried separately in lfsr.
    function automatic logic [N_IN-1:0] gen_vec(
        input logic [1:0]      m,
        input logic [N_IN:0]   i,
        input logic [N_IN-1:0] l
    );
        logic [N_IN-1:0] ib;
        ib = i[N_IN-1:0];
        case (m)
            MODE_BIN:  gen_vec = ib;
            MODE_GRAY: gen_vec = ib ^ (ib >> 1);
            MODE_WALK: gen_vec = ONE_HOT0 << i;
            default:   gen_vec = l;
        endcase
    endfunction

    // Fibonacci step: shift left, feedback is parity of the tapped bits.
    function automatic logic [N_IN-1:0] lfsr_step(input logic [N_IN-1:0] l);
        lfsr_step = {l[N_IN-2:0], ^(l & LFSR_TAPS)};
    endfunction

    assign accept   = vec_valid & vec_ready;
    assign idx_inc  = vec_idx + 1'b1;
    assign lfsr_adv = lfsr_step(lfsr);
    assign busy     = (state == RUN);

    // Last index depends on the pattern latched at start, not the live input.
    always_comb begin
        case (mode_q)
            MODE_WALK: last_idx = LAST_WALK;
            MODE_LFSR: last_idx = LAST_LFSR;
            default:   last_idx = LAST_FULL;
        endcase
    end

    // Next-state and next-output decode; abort outranks start and acceptance.
    always_comb begin
        state_n     = state;
        mode_n      = mode_q;
        lfsr_n      = lfsr;
        vec_out_n   = vec_out;
        vec_valid_n = vec_valid;
        vec_idx_n   = vec_idx;
        done_n      = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (start) begin
                    state_n     = RUN;
                    mode_n      = mode;
                    lfsr_n      = LFSR_SEED;
                    vec_idx_n   = '0;
                    vec_out_n   = gen_vec(mode, '0, LFSR_SEED);
                    vec_valid_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end

            RUN: begin
                if (abort) begin
                    state_n     = IDLE;
                    vec_valid_n = 1'b0;
                    vec_idx_n   = '0;
                    lfsr_n      = LFSR_SEED;
                end else if (accept) begin
                    if (vec_idx == last_idx) begin
                        // vec_out and vec_idx keep the final vector for the capture side.
                        state_n     = DONE;
                        vec_valid_n = 1'b0;
                        done_n      = 1'b1;
                    end else begin
                        vec_idx_n = idx_inc;
                        lfsr_n    = lfsr_adv;
                        vec_out_n = gen_vec(mode_q, idx_inc, lfsr_adv);
                    end
                end
            end

            default: begin
                state_n     = IDLE;
                vec_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= MODE_BIN;
            lfsr      <= LFSR_SEED;
            vec_out   <= '0;
            vec_valid <= 1'b0;
            vec_idx   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            lfsr      <= lfsr_n;
            vec_out   <= vec_out_n;
            vec_valid <= vec_valid_n;
            vec_idx   <= vec_idx_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
module tb_gate_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       vec_ready = 1'b0;
    logic [2:0] vec_out;
    logic       vec_valid;
    logic [3:0] vec_idx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       is_done;
        logic [2:0] vec;
        logic [3:0] idx;
    } exp_t;

    exp_t sb[$];

    logic       stall_prev = 1'b0;
    logic [2:0] prev_vec = '0;
    logic [3:0] prev_idx = '0;

    gate_vector_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .vec_ready (vec_ready),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic ok, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Hand-written pattern tables.
    function automatic logic [2:0] exp_vec(input logic [1:0] m, input int i);
        logic [2:0] t[8];
        case (m)
            2'd0: t = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
            2'd1: t = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
            2'd2: t = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
            default: t = '{3'b111, 3'b110, 3'b100, 3'b001, 3'b010, 3'b101, 3'b011, 3'b000};
        endcase
        return t[i];
    endfunction

    function automatic int seq_len(input logic [1:0] m);
        case (m)
            2'd2: return 3;
            2'd3: return 7;
            default: return 8;
        endcase
    endfunction

    task automatic push_vec(input logic [2:0] v, input int i);
        exp_t e;
        e.is_done = 1'b0;
        e.vec = v;
        e.idx = 4'(i);
        sb.push_back(e);
    endtask

    task automatic push_done(input int i);
        exp_t e;
        e.is_done = 1'b1;
        e.vec = '0;
        e.idx = 4'(i);
        sb.push_back(e);
    endtask

    // Scoreboard monitor: pops one entry per accepted vector and per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (vec_valid && vec_ready && !abort) begin
                if (sb.size() == 0) begin
                    check("unexpected_accept", 1'b0, int'(vec_idx), -1);
                end else begin
                    e = sb.pop_front();
                    check("accept_kind", !e.is_done, 0, 0);
                    check("accept_vec", vec_out == e.vec, int'(vec_out), int'(e.vec));
                    check("accept_idx", vec_idx == e.idx, int'(vec_idx), int'(e.idx));
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1'b0, 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_kind", e.is_done, 0, 1);
                    check("done_idx", vec_idx == e.idx, int'(vec_idx), int'(e.idx));
                    check("done_valid_low", !vec_valid, int'(vec_valid), 0);
                end
            end
            if (stall_prev && vec_valid) begin
                check("stall_vec_stable", vec_out == prev_vec, int'(vec_out), int'(prev_vec));
                check("stall_idx_stable", vec_idx == prev_idx, int'(vec_idx), int'(prev_idx));
            end
            stall_prev = vec_valid && !vec_ready && !abort;
            prev_vec   = vec_out;
            prev_idx   = vec_idx;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_latency_valid", vec_valid, int'(vec_valid), 1);
        check("start_busy", busy, int'(busy), 1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            if (done) break;
            tick();
        end
        if (!done) check({name, "_timeout"}, 1'b0, k, budget);
    endtask

    task automatic run_full(input logic [1:0] m);
        int len;
        len = seq_len(m);
        for (int i = 0; i < len; i++) push_vec(exp_vec(m, i), i);
        push_done(len - 1);
        vec_ready = 1'b1;
        pulse_start(m);
        check("first_vec", vec_out == exp_vec(m, 0), int'(vec_out), int'(exp_vec(m, 0)));
        wait_done(40, "run_full");
        check("after_done_valid", !vec_valid, int'(vec_valid), 0);
        check("after_done_idx", vec_idx == 4'(len - 1), int'(vec_idx), len - 1);
        check("after_done_vec", vec_out == exp_vec(m, len - 1), int'(vec_out), int'(exp_vec(m, len - 1)));
        tick();
        check("done_one_cycle", !done, int'(done), 0);
        check("idle_busy", !busy, int'(busy), 0);
        check("idle_idx_hold", vec_idx == 4'(len - 1), int'(vec_idx), len - 1);
        check("sb_drained", sb.size() == 0, sb.size(), 0);
    endtask

    task automatic wait_idx(input int target);
        int k;
        for (k = 0; k < 40; k++) begin
            if (vec_valid && vec_idx == 4'(target)) break;
            tick();
        end
        if (!(vec_valid && vec_idx == 4'(target))) check("wait_idx_timeout", 1'b0, int'(vec_idx), target);
    endtask

    initial begin
        int dcount;
        int cyc;

        // Reset values with no clock edge required.
        #1;
        check("rst_vec_out", vec_out == 3'd0, int'(vec_out), 0);
        check("rst_valid", !vec_valid, int'(vec_valid), 0);
        check("rst_idx", vec_idx == 4'd0, int'(vec_idx), 0);
        check("rst_busy", !busy, int'(busy), 0);
        check("rst_done", !done, int'(done), 0);
        #20;
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_no_start", !vec_valid, int'(vec_valid), 0);

        run_full(2'd0);
        run_full(2'd1);
        run_full(2'd2);
        run_full(2'd3);

        // Stalling consumer, plus start/mode change mid-run that must be ignored.
        for (int i = 0; i < 8; i++) push_vec(exp_vec(2'd0, i), i);
        push_done(7);
        vec_ready = 1'b0;
        pulse_start(2'd0);
        for (cyc = 0; cyc < 60; cyc++) begin
            vec_ready = (cyc % 3 == 0);
            if (cyc == 4) begin
                start = 1'b1;
                mode = 2'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) break;
        end
        start = 1'b0;
        check("stall_done_seen", done, cyc, 60);
        vec_ready = 1'b1;
        tick();
        check("stall_sb_drained", sb.size() == 0, sb.size(), 0);

        // Abort at idx 3 while the consumer is also accepting.
        for (int i = 0; i < 3; i++) push_vec(exp_vec(2'd3, i), i);
        vec_ready = 1'b1;
        pulse_start(2'd3);
        wait_idx(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", !vec_valid, int'(vec_valid), 0);
        check("abort_idx", vec_idx == 4'd0, int'(vec_idx), 0);
        check("abort_busy", !busy, int'(busy), 0);
        dcount = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) dcount++;
            tick();
        end
        check("abort_no_done", dcount == 0, dcount, 0);
        check("abort_sb_drained", sb.size() == 0, sb.size(), 0);
        run_full(2'd3);

        // Start and abort together: abort wins.
        vec_ready = 1'b1;
        mode = 2'd0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_valid", !vec_valid, int'(vec_valid), 0);
        check("start_abort_busy", !busy, int'(busy), 0);

        // Asynchronous reset mid-run at idx 5.
        for (int i = 0; i < 5; i++) push_vec(exp_vec(2'd0, i), i);
        pulse_start(2'd0);
        wait_idx(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_vec", vec_out == 3'd0, int'(vec_out), 0);
        check("async_rst_valid", !vec_valid, int'(vec_valid), 0);
        check("async_rst_idx", vec_idx == 4'd0, int'(vec_idx), 0);
        check("async_rst_busy", !busy, int'(busy), 0);
        tick();
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 6; k++) begin
            if (vec_valid || busy || done) cyc++;
            tick();
        end
        check("post_rst_quiet", cyc == 0, cyc, 0);
        check("rst_sb_drained", sb.size() == 0, sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
- Stimulus stage directly upstream of the three-input gate cell (XOR/XNOR/NOT/AND outputs).
- Generates input vectors {a,b,c} under one of four selectable patterns and presents them with a valid/ready handshake.
- Downstream is the gate cell plus its capture logic.
- Replaces free-running testbench delays with a clocked, countable, abortable sequence.

Parameters:
- N_IN, 3, vector width; bit N_IN-1 drives a, bit 1 drives b, bit 0 drives c.
- LFSR_TAPS, 3'b110, Fibonacci feedback mask, N_IN bits wide; must be maximal-length for N_IN.
- LFSR_SEED, 3'b111, LFSR start value; must be nonzero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; sampled only in IDLE or DONE.
- abort  in  1  level; forces return to IDLE.
- mode  in  2  pattern select, latched on start: 0 binary, 1 Gray, 2 walking-one, 3 LFSR.
- vec_ready  in  1  consumer accepts vec_out this cycle.
- vec_out  out  N_IN  current vector (a,b,c).
- vec_valid  out  1  vec_out is meaningful.
- vec_idx  out  N_IN+1  index of the current vector, 0-based.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the last vector is accepted.

Behaviour:
- Reset values (immediate on rst_n low, no clock needed): state IDLE, vec_out 0, vec_valid 0, vec_idx 0, busy 0, done 0, latched mode 0, LFSR register = LFSR_SEED.
- States:
  - IDLE: start → RUN (latch mode, idx=0, load first vector).
  - RUN: last vector accepted → DONE; abort → IDLE.
  - DONE: start → RUN (restart); otherwise return to IDLE after one cycle.
- Latency: vec_valid=1 and the first vector appear on the first rising edge after start is sampled.
- Handshake:
  - vec_out and vec_idx hold stable while vec_valid=1 and vec_ready=0.
  - On a cycle with vec_valid and vec_ready, the next vector and idx+1 are registered at that edge, so back-to-back acceptance gives one vector per cycle.
  - vec_valid never drops mid-sequence except on abort.
- Vector count L:
  - modes 0 and 1: 2^N_IN
  - mode 2: N_IN
  - mode 3: 2^N_IN − 1
- Vector at idx i:
  - mode 0: i[N_IN-1:0]
  - mode 1: i ^ (i>>1)
  - mode 2: 1 << i
  - mode 3: LFSR state, starting at LFSR_SEED; next = {lfsr[N_IN-2:0], ^(lfsr & LFSR_TAPS)}.
- Last-vector handling:
  - Acceptance of idx L−1 gives vec_valid=0, done=1 for one cycle, state DONE, and vec_out holds its last value.
  - vec_idx stays at L−1 in DONE, and returns to 0 only on the next start or on reset.
- start while in RUN is ignored; mode changes while in RUN are ignored.
- abort has priority over acceptance in the same cycle: next edge gives IDLE, vec_valid=0, idx=0, no done pulse, LFSR reloaded to seed.
- abort in IDLE or DONE: go to IDLE, no other effect.
- start and abort in the same cycle: abort wins.
- Reset asserted mid-sequence: all outputs take reset values immediately; after release, the block stays in IDLE until a fresh start.
- vec_idx width N_IN+1 holds L−1 without overflow for every mode.

Test Plan:
- Reset then start with mode=0 and vec_ready held at 1 → vec_out 000,001,…,111 on 8 consecutive cycles with vec_idx 0..7; done pulses in the cycle after 111 is accepted; vec_valid=0 afterward.
- mode=1, vec_ready=1 → sequence 000,001,011,010,110,111,101,100; mode=2 → 001,010,100 followed by done.
- mode=3 → sequence 111,110,100,001,010,101,011 (7 vectors), no 000 produced; done after 011.
- mode=0, vec_ready toggling 1,0,0,1,… → each vector stays stable through the stall cycles, and no index is skipped or repeated (check the idx vs. accept count).
- abort asserted at idx=3 together with vec_ready=1 → IDLE on the next edge, vec_valid=0, idx=0, no done pulse; a following start restarts at 000 (mode 3 restarts at 111).
- rst_n pulled low asynchronously mid-run at idx=5 → outputs zero immediately without a clock edge; after release there is no activity until start.
